// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding a DEPTH-entry instruction queue.
// Define IFU_PERF_COUNTER_EN to add the perf_fetched delivered-instruction counter port.
module instruction_fetch_unit #(
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       PCSIZE    = 64,
    parameter int unsigned       INSTRSIZE = 32,
    parameter int unsigned       ADDRSIZE  = 8,
    parameter logic [PCSIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [ADDRSIZE-1:0]  imem_addr,
    input  logic                 imem_ack,
    input  logic [INSTRSIZE-1:0] imem_data,
    input  logic                 redirect,
    input  logic [PCSIZE-1:0]    redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTRSIZE-1:0] out_instr,
    output logic [PCSIZE-1:0]    out_pc
`ifdef IFU_PERF_COUNTER_EN
    ,
    output logic [31:0]          perf_fetched
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PCSIZE-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDRSIZE-1:0] req_addr_q, req_addr_d;
    logic                started_q, started_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;

    logic [PCSIZE-1:0]    pc_mem    [DEPTH];
    logic [INSTRSIZE-1:0] instr_mem [DEPTH];

    logic push;
    logic pop;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign push      = (state_q == WAIT) && imem_ack && !redirect;
    assign imem_req  = (state_q != IDLE);
    assign imem_addr = req_addr_q;
    assign out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;
    assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;

    // started_q holds off the first request until the second edge after reset release.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        started_d  = 1'b1;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        case (state_q)
            IDLE: begin
                if (started_q && !redirect && (count_q < CW'(DEPTH))) begin
                    state_d    = WAIT;
                    req_addr_d = fetch_pc_q[ADDRSIZE-1:0];
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    state_d = IDLE;
                    if (!redirect) begin
                        fetch_pc_d = fetch_pc_q + PCSIZE'(1);
                    end
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // A redirect still lets this cycle's head transfer complete; the flush only drops what remains.
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC[ADDRSIZE-1:0];
            started_q  <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            started_q  <= started_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
            instr_mem[wr_ptr_q] <= imem_data;
        end
    end

`ifdef IFU_PERF_COUNTER_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (pop) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_fetched = perf_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table, multi-cycle corner
// sequences, and a randomized run checked against a stream-level scoreboard.
module tb_instruction_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
`ifdef IFU_PERF_COUNTER_EN
    logic [31:0] perf_fetched;
`endif

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .DEPTH    (DEPTH),
        .PCSIZE   (64),
        .INSTRSIZE(32),
        .ADDRSIZE (8),
        .RESET_PC (64'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc)
`ifdef IFU_PERF_COUNTER_EN
        ,
        .perf_fetched(perf_fetched)
`endif
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input logic [63:0] pc);
        return 32'h0000_0013 + {pc[23:0], 8'h00};
    endfunction

    task automatic apply_reset();
        rst         = 1'b0;
        imem_ack    = 1'b0;
        imem_data   = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    typedef struct {
        logic        ack;
        logic        ready;
        logic        e_req;
        logic [7:0]  e_addr;
        logic        e_valid;
        logic [63:0] e_pc;
    } vec_t;

    vec_t vecs[11];

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_next_pc;
    logic [63:0] m_req_pc;
    logic [7:0]  m_addr;
    bit          m_out;
    bit          m_live;
    int unsigned m_perf;

    initial begin
        int unsigned acks;
        logic [31:0] perf0;
        logic [63:0] first_pc;
        bit          got_first;
        bit          bad_seen;
        logic        r_ack, r_ready, r_redir;
        logic [63:0] r_rpc;
        logic [31:0] r_data;

        // Streaming after reset: ack each request, consume each instruction.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 64'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 64'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 64'h0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 64'h0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 64'h1};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 64'h0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 64'h2};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 64'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 64'h3};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h04, 1'b0, 64'h0};

        // Reset state, then reset asserted while a request is outstanding.
        apply_reset();
        rst = 1'b0;
        tick();
        chk("reset_req", imem_req, 1'b0);
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_pc", out_pc, 64'h0);
        chk("reset_instr", out_instr, 32'h0);
`ifdef IFU_PERF_COUNTER_EN
        chk("reset_perf", perf_fetched, 32'h0);
`endif
        rst = 1'b1;
        tick();
        chk("startup_no_req_1st_edge", imem_req, 1'b0);
        tick();
        chk("startup_req", imem_req, 1'b1);
        chk("startup_addr", imem_addr, 8'h00);
        #2 rst = 1'b0;
        #1;
        chk("midwait_reset_req", imem_req, 1'b0);
        chk("midwait_reset_valid", out_valid, 1'b0);
        tick();
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            chk($sformatf("vec%0d_req", i), imem_req, vecs[i].e_req);
            if (vecs[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].e_pc);
                chk($sformatf("vec%0d_instr", i), out_instr, word(vecs[i].e_pc));
            end
            imem_ack  = vecs[i].ack;
            out_ready = vecs[i].ready;
            imem_data = word({56'h0, imem_addr});
            tick();
        end
        imem_ack  = 1'b0;
        out_ready = 1'b0;

        // Backpressure: queue fills to DEPTH, then a single pop allows exactly one new fetch.
        apply_reset();
        acks = 0;
        for (int i = 0; i < 24; i++) begin
            imem_ack  = imem_req;
            imem_data = word({56'h0, imem_addr});
            if (imem_req) acks++;
            tick();
        end
        imem_ack = 1'b0;
        chk("bp_acks", acks, DEPTH);
        chk("bp_req_idle", imem_req, 1'b0);
        chk("bp_head_pc", out_pc, 64'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        acks = 0;
        for (int i = 0; i < 16; i++) begin
            imem_ack  = imem_req;
            imem_data = word({56'h0, imem_addr});
            if (imem_req) acks++;
            tick();
        end
        imem_ack = 1'b0;
        chk("bp_refill_acks", acks, 1);
        chk("bp_refill_req_idle", imem_req, 1'b0);
        chk("bp_next_head_pc", out_pc, 64'h1);

        // Redirect while waiting; the late ack is dropped.
        apply_reset();
        tick();
        tick();
        chk("rdw_req", imem_req, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 64'h40;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rdw_drop_req", imem_req, 1'b1);
            chk("rdw_drop_addr", imem_addr, 8'h00);
            tick();
        end
        chk("rdw_drop_addr_ack", imem_addr, 8'h00);
        imem_ack  = 1'b1;
        imem_data = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("rdw_idle_req", imem_req, 1'b0);
        chk("rdw_idle_valid", out_valid, 1'b0);
        tick();
        chk("rdw_new_req", imem_req, 1'b1);
        chk("rdw_new_addr", imem_addr, 8'h40);
        imem_ack  = 1'b1;
        imem_data = word(64'h40);
        tick();
        imem_ack = 1'b0;
        chk("rdw_out_valid", out_valid, 1'b1);
        chk("rdw_out_pc", out_pc, 64'h40);
        chk("rdw_out_instr", out_instr, word(64'h40));

        // Redirect coinciding with both an ack and an out handshake.
        apply_reset();
        tick();
        tick();
        imem_ack  = 1'b1;
        imem_data = word(64'h0);
        tick();
        imem_ack = 1'b0;
        tick();
        chk("sim_pre_req", imem_req, 1'b1);
        chk("sim_pre_addr", imem_addr, 8'h01);
        chk("sim_pre_valid", out_valid, 1'b1);
        chk("sim_pre_pc", out_pc, 64'h0);
`ifdef IFU_PERF_COUNTER_EN
        perf0 = perf_fetched;
`else
        perf0 = '0;
`endif
        imem_ack    = 1'b1;
        imem_data   = 32'hBAD1_1111;
        redirect    = 1'b1;
        redirect_pc = 64'h80;
        out_ready   = 1'b1;
        tick();
        imem_ack  = 1'b0;
        redirect  = 1'b0;
        out_ready = 1'b0;
        chk("sim_flush_valid", out_valid, 1'b0);
        chk("sim_flush_req", imem_req, 1'b0);
`ifdef IFU_PERF_COUNTER_EN
        chk("sim_perf_once", perf_fetched, perf0 + 32'd1);
`endif
        got_first = 1'b0;
        bad_seen  = 1'b0;
        first_pc  = '1;
        for (int i = 0; i < 12 && !got_first; i++) begin
            if (out_valid) begin
                got_first = 1'b1;
                first_pc  = out_pc;
                if (out_instr == 32'hBAD1_1111) bad_seen = 1'b1;
            end
            imem_ack  = imem_req;
            imem_data = word({56'h0, imem_addr});
            tick();
        end
        imem_ack = 1'b0;
        chk("sim_got_first", got_first, 1'b1);
        chk("sim_first_pc", first_pc, 64'h80);
        chk("sim_ack_data_dropped", bad_seen, 1'b0);
`ifdef IFU_PERF_COUNTER_EN
        chk("sim_perf_hold", perf_fetched, perf0 + 32'd1);
`endif

        // Randomized run against a stream-level scoreboard.
        apply_reset();
        mq.delete();
        m_next_pc = 64'h0;
        m_req_pc  = 64'h0;
        m_addr    = 8'h0;
        m_out     = 1'b0;
        m_live    = 1'b0;
        m_perf    = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("rnd_pc", out_pc, mq[0].pc);
                chk("rnd_instr", out_instr, mq[0].instr);
            end
`ifdef IFU_PERF_COUNTER_EN
            chk("rnd_perf", perf_fetched, m_perf);
`endif
            if (!m_out && imem_req) begin
                chk("rnd_req_addr", imem_addr, m_next_pc[7:0]);
                chk("rnd_req_room", mq.size() < DEPTH, 1'b1);
                m_out    = 1'b1;
                m_live   = 1'b1;
                m_addr   = imem_addr;
                m_req_pc = m_next_pc;
            end else if (m_out) begin
                chk("rnd_req_held", imem_req, 1'b1);
                chk("rnd_addr_held", imem_addr, m_addr);
            end

            r_ack   = m_out && ($urandom_range(0, 2) != 0);
            r_ready = ($urandom_range(0, 3) != 0);
            r_redir = ($urandom_range(0, 24) == 0);
            r_rpc   = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom, $urandom};
            r_data  = $urandom;

            if (mq.size() != 0 && r_ready) begin
                void'(mq.pop_front());
                m_perf++;
            end
            if (m_out && r_ack) begin
                if (m_live && !r_redir) begin
                    mq.push_back('{m_req_pc, r_data});
                    m_next_pc = m_req_pc + 64'd1;
                end
                m_out = 1'b0;
            end
            if (r_redir) begin
                mq.delete();
                m_next_pc = r_rpc;
                m_live    = 1'b0;
            end

            imem_ack    = r_ack;
            out_ready   = r_ready;
            redirect    = r_redir;
            redirect_pc = r_rpc;
            imem_data   = r_data;
            tick();
        end
        imem_ack  = 1'b0;
        out_ready = 1'b0;
        redirect  = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
